max_pool_2x2: RTL and testbench

- Streaming 2x2 max-pooling stage, stride 2, placed directly downstream of the ReLu activation stage in the CNN digit-classification datapath.
- Consumes one activated feature-map pixel per valid beat, in raster order (row-major, left to right).
- Produces one pooled pixel per 2x2 window, using a half-width line buffer.
- The pooled map (IMG_W/2 x IMG_H/2) feeds the flatten/fully-connected stage.

---
 rtl/max_pool_2x2_if.sv | 30 +++
 rtl/max_pool_2x2.sv | 106 ++++++++++
 tb/tb_max_pool_2x2.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle between the ReLu stage, the 2x2 max-pool stage and the
// flatten stage: one signed pixel in per valid beat, one pooled pixel out per
// window.
interface max_pool_2x2_if #(
    parameter int w1 = 9
);
    logic signed [w1-1:0] din;
    logic                 din_valid;
    logic signed [w1-1:0] dout;
    logic                 dout_valid;
    logic                 frame_done;

    // Upstream/observer side: drives pixels, watches pooled results.
    modport master (
        output din,
        output din_valid,
        input  dout,
        input  dout_valid,
        input  frame_done
    );

    // Pooling stage side.
    modport slave (
        input  din,
        input  din_valid,
        output dout,
        output dout_valid,
        output frame_done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order feature map.
// Even rows reduce each horizontal pixel pair into a half-width line buffer;
// odd rows reduce their pair and merge it with the stored pair from the row
// above, emitting one pooled pixel one cycle after the window's last beat.
module max_pool_2x2 #(
    parameter int w1    = 9,
    parameter int IMG_W = 26,
    parameter int IMG_H = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    max_pool_2x2_if.slave      bus
);

    localparam int HALF = IMG_W / 2;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW   = (HALF > 1)  ? $clog2(HALF)  : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    function automatic logic signed [w1-1:0] smax(
        input logic signed [w1-1:0] a,
        input logic signed [w1-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic signed [w1-1:0] hold_q, hold_d;
    logic signed [w1-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 frame_done_q, frame_done_d;

    // Line buffer is written before it is read in every frame, so it carries
    // no reset.
    logic signed [w1-1:0] line_buf [HALF];
    logic [BW-1:0]        lb_idx;
    logic                 lb_we;
    logic signed [w1-1:0] pair_max;

    // Pair reduction, window merge and raster position tracking.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        lb_idx       = BW'(col_q >> 1);
        pair_max     = smax(hold_q, bus.din);

        if (bus.din_valid) begin
            if (!col_q[0]) begin
                hold_d = bus.din;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                dout_d       = smax(line_buf[lb_idx], pair_max);
                dout_valid_d = 1'b1;
                frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counters, holding register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Store the even-row pair maximum for the matching odd-row pair.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_idx] <= pair_max;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: a 4x4 instance for the directed scenarios and a
// default 26x26 instance for a randomized full frame.
module tb_max_pool_2x2;

    logic clk;
    logic rst_n;

    max_pool_2x2_if #(.w1(9)) bs ();
    max_pool_2x2_if #(.w1(9)) bl ();

    max_pool_2x2 #(.w1(9), .IMG_W(4), .IMG_H(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    max_pool_2x2 #(.w1(9), .IMG_W(26), .IMG_H(26)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bl.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state per instance (0 = 4x4, 1 = 26x26).
    int pix  [2][26*26];
    int k    [2];
    bit pend [2];
    int eval [2];
    bit efd  [2];
    int last [2];
    int nfd  [2];
    int nout [2];
    int cap  [$];
    int want [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One clock: check what the previous edge produced, then present a beat.
    task automatic step(input int b, input bit v, input int d);
        int ov, od, ofd, r, c, w, p;
        w = (b != 0) ? 26 : 4;
        @(negedge clk);
        if (b != 0) begin
            ov = int'(bl.dout_valid); od = int'(bl.dout); ofd = int'(bl.frame_done);
        end else begin
            ov = int'(bs.dout_valid); od = int'(bs.dout); ofd = int'(bs.frame_done);
        end
        chk("dout_valid", ov, int'(pend[b]));
        chk("frame_done", ofd, pend[b] ? int'(efd[b]) : 0);
        chk("dout", od, pend[b] ? eval[b] : last[b]);
        if (ov != 0) begin
            nout[b]++;
            if (b == 0) cap.push_back(od);
        end
        if (ofd != 0) nfd[b]++;
        if (pend[b]) last[b] = eval[b];
        pend[b] = 1'b0;

        if (v) begin
            r = k[b] / w;
            c = k[b] % w;
            pix[b][k[b]] = d;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                p = imax(imax(pix[b][(r-1)*w + c-1], pix[b][(r-1)*w + c]),
                         imax(pix[b][r*w + c-1], d));
                pend[b] = 1'b1;
                eval[b] = p;
                efd[b]  = (k[b] == w*w - 1);
            end
            k[b] = (k[b] + 1) % (w*w);
        end

        if (b != 0) begin
            bl.din = 9'(d); bl.din_valid = v;
        end else begin
            bs.din = 9'(d); bs.din_valid = v;
        end
    endtask

    task automatic idle(input int b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0, 0);
    endtask

    task automatic clear_stats();
        cap.delete();
        for (int i = 0; i < 2; i++) begin
            nfd[i] = 0; nout[i] = 0;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        step(0, 1'b0, 0);
        step(1, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dout_s", int'(bs.dout), 0);
        chk("rst_dv_s",   int'(bs.dout_valid), 0);
        chk("rst_fd_s",   int'(bs.frame_done), 0);
        chk("rst_dout_l", int'(bl.dout), 0);
        chk("rst_dv_l",   int'(bl.dout_valid), 0);
        chk("rst_fd_l",   int'(bl.frame_done), 0);
        @(posedge clk); #1;
        chk("rst_hold_dv_s", int'(bs.dout_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; pend[i] = 1'b0; last[i] = 0;
        end
        clear_stats();
    endtask

    task automatic check_caps(input string tag);
        chk({tag, "_count"}, cap.size(), want.size());
        for (int i = 0; i < want.size() && i < cap.size(); i++)
            chk(tag, cap[i], want[i]);
    endtask

    int sgn [16];
    int sent;
    bit v;

    initial begin
        rst_n = 1'b0;
        bs.din = '0; bs.din_valid = 1'b0;
        bl.din = '0; bl.din_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; pend[i] = 1'b0; eval[i] = 0; efd[i] = 1'b0; last[i] = 0;
        end
        clear_stats();
        do_reset();

        // Ramp 0..15, continuous valid.
        for (int i = 0; i < 16; i++) step(0, 1'b1, i);
        idle(0, 3);
        want = '{5, 7, 13, 15};
        check_caps("ramp");
        chk("ramp_frame_done", nfd[0], 1);

        // Signed mix.
        clear_stats();
        sgn = '{-3, -1, -8, -2, -4, -5, -7, -9, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) step(0, 1'b1, sgn[i]);
        idle(0, 3);
        want = '{-1, -2, 0, 0};
        check_caps("signed");

        // Ramp with random valid gaps.
        clear_stats();
        sent = 0;
        while (sent < 16) begin
            v = 1'($urandom_range(0, 1));
            step(0, v, v ? sent : 0);
            if (v) sent++;
        end
        idle(0, 3);
        want = '{5, 7, 13, 15};
        check_caps("gaps");

        // Two frames back-to-back: ascending then descending.
        clear_stats();
        for (int i = 0; i < 16; i++) step(0, 1'b1, i);
        for (int i = 0; i < 16; i++) step(0, 1'b1, 15 - i);
        idle(0, 3);
        want = '{5, 7, 13, 15, 15, 13, 7, 5};
        check_caps("b2b");
        chk("b2b_frame_done", nfd[0], 2);

        // Partial frame abandoned by reset, then a clean ramp.
        for (int i = 0; i < 9; i++) step(0, 1'b1, 100 + i);
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1'b1, i);
        idle(0, 3);
        want = '{5, 7, 13, 15};
        check_caps("post_reset");
        chk("post_reset_frame_done", nfd[0], 1);

        // Full 26x26 random frame with occasional gaps.
        clear_stats();
        sent = 0;
        while (sent < 26*26) begin
            v = ($urandom_range(0, 3) != 0);
            step(1, v, v ? (int'($urandom_range(0, 511)) - 256) : 0);
            if (v) sent++;
        end
        idle(1, 3);
        chk("big_outputs", nout[1], 169);
        chk("big_frame_done", nfd[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
